// File: rtl/rat_io_pkg.sv
// rat_io_pkg
// Shared definitions for the RAT MCU I/O wrapper: the button-conditioning
// FSM state type, the wrapper's input/output port IDs, and a width helper
// for parameterised counters.
package rat_io_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        PULSE        = 3'd2,
        HELD         = 3'd3,
        RELEASE_WAIT = 3'd4
    } btn_state_t;

    // Input port IDs
    localparam logic [7:0] BTN_COUNT_ID = 8'h20;
    localparam logic [7:0] SWITCHES_ID  = 8'hFF;

    // Output port IDs
    localparam logic [7:0] LEDS_ID      = 8'h40;
    localparam logic [7:0] SEG_ID       = 8'h81;

    // Bits needed to hold values 0 .. n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_intr_debounce_if.sv
// btn_intr_debounce_if
// Groups the button-conditioning signals between the raw button source,
// the debounce block and the MCU wrapper.
//   BTN_IN      raw asynchronous button level, active-high
//   INTR        one-shot interrupt pulse to the MCU
//   BTN_DB      debounced button level
//   PRESS_COUNT wrapping count of accepted presses
// Modports:
//   master  side that drives the button and consumes the results
//   slave   the debounce block
interface btn_intr_debounce_if;

    logic       BTN_IN;
    logic       INTR;
    logic       BTN_DB;
    logic [7:0] PRESS_COUNT;

    modport master (
        output BTN_IN,
        input  INTR,
        input  BTN_DB,
        input  PRESS_COUNT
    );

    modport slave (
        input  BTN_IN,
        output INTR,
        output BTN_DB,
        output PRESS_COUNT
    );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
// One-bit two-flop synchronizer bringing an asynchronous level into the
// CLK domain. Both flops clear to 0 on reset.
//   CLK    clock
//   RESET  asynchronous active-high reset
//   d      asynchronous input level
//   q      synchronized level, two CLK edges behind d
module sync_2ff (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_intr_debounce.sv
// btn_intr_debounce
// Turns a raw bouncing push-button level into one fixed-width INTR pulse
// per accepted press, a debounced level BTN_DB, and an 8-bit wrapping
// press counter for the wrapper's input-port mux.
//   CLK    clock (MCU domain)
//   RESET  asynchronous active-high reset, clears all state
//   bus    slave side of btn_intr_debounce_if (BTN_IN in; INTR, BTN_DB,
//          PRESS_COUNT out, all outputs registered)
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | button released and accepted as released
// PRESS_WAIT   | counting consecutive high samples toward press acceptance
// PULSE        | press accepted, INTR high, input ignored
// HELD         | press accepted, pulse finished, waiting for a low sample
// RELEASE_WAIT | counting consecutive low samples toward release acceptance
module btn_intr_debounce
    import rat_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    btn_intr_debounce_if.slave   bus
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int PW = cnt_width(PULSE_CYCLES + 1);

    // The counter holds the number of stable samples already seen, so the
    // sample that completes the run arrives while it reads DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES);
    localparam logic [CW-1:0] DB_ONE     = CW'(1);
    localparam logic [PW-1:0] P_ONE      = PW'(1);

    logic          s_btn;

    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] db_cnt_nxt;
    logic [PW-1:0] p_cnt;
    logic [PW-1:0] p_cnt_nxt;
    logic          intr_q;
    logic          intr_nxt;
    logic          btn_db_q;
    logic          btn_db_nxt;
    logic [7:0]    press_q;
    logic [7:0]    press_nxt;

    sync_2ff u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (bus.BTN_IN),
        .q     (s_btn)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            db_cnt   <= '0;
            p_cnt    <= '0;
            intr_q   <= 1'b0;
            btn_db_q <= 1'b0;
            press_q  <= 8'h00;
        end else begin
            state    <= state_nxt;
            db_cnt   <= db_cnt_nxt;
            p_cnt    <= p_cnt_nxt;
            intr_q   <= intr_nxt;
            btn_db_q <= btn_db_nxt;
            press_q  <= press_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        p_cnt_nxt  = p_cnt;
        intr_nxt   = intr_q;
        btn_db_nxt = btn_db_q;
        press_nxt  = press_q;

        case (state)
            IDLE: begin
                if (s_btn) begin
                    state_nxt  = PRESS_WAIT;
                    db_cnt_nxt = DB_ONE;
                end
            end

            PRESS_WAIT: begin
                if (!s_btn) begin
                    state_nxt  = IDLE;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = PULSE;
                    db_cnt_nxt = '0;
                    p_cnt_nxt  = P_ONE;
                    intr_nxt   = 1'b1;
                    btn_db_nxt = 1'b1;
                    press_nxt  = press_q + 8'd1;
                end else begin
                    db_cnt_nxt = db_cnt + DB_ONE;
                end
            end

            // p_cnt counts cycles INTR has already been high.
            PULSE: begin
                if (p_cnt == PULSE_LAST) begin
                    state_nxt = HELD;
                    p_cnt_nxt = '0;
                    intr_nxt  = 1'b0;
                end else begin
                    p_cnt_nxt = p_cnt + P_ONE;
                end
            end

            HELD: begin
                if (!s_btn) begin
                    state_nxt  = RELEASE_WAIT;
                    db_cnt_nxt = DB_ONE;
                end
            end

            RELEASE_WAIT: begin
                if (s_btn) begin
                    state_nxt  = HELD;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = IDLE;
                    db_cnt_nxt = '0;
                    btn_db_nxt = 1'b0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_ONE;
                end
            end

            default: begin
                state_nxt  = IDLE;
                db_cnt_nxt = '0;
                p_cnt_nxt  = '0;
                intr_nxt   = 1'b0;
                btn_db_nxt = 1'b0;
            end
        endcase
    end

    assign bus.INTR        = intr_q;
    assign bus.BTN_DB      = btn_db_q;
    assign bus.PRESS_COUNT = press_q;

endmodule

// File: tb/tb_btn_intr_debounce.sv
module tb_btn_intr_debounce;

    localparam int DB = 4;
    localparam int PC = 3;

    logic CLK;
    logic RESET;

    btn_intr_debounce_if bif ();

    btn_intr_debounce #(
        .DEBOUNCE_CYCLES (DB),
        .PULSE_CYCLES    (PC)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a press/release is accepted once the synchronized
    // level has disagreed with the accepted level for DB consecutive
    // samples; after a press the input is ignored for PC samples while
    // INTR is high.
    logic       m_sync1, m_sync2;
    logic       m_db;
    int         m_run;
    int         m_ignore;
    logic       m_intr;
    logic [7:0] m_count;

    int n_total;
    int n_pass;
    int obs_pulses;
    logic prev_intr;

    task automatic model_reset();
        m_sync1  = 1'b0;
        m_sync2  = 1'b0;
        m_db     = 1'b0;
        m_run    = 0;
        m_ignore = 0;
        m_intr   = 1'b0;
        m_count  = 8'h00;
        obs_pulses = 0;
        prev_intr  = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        logic s_seen;
        s_seen  = m_sync2;
        m_sync2 = m_sync1;
        m_sync1 = b;
        if (m_ignore > 0) begin
            m_ignore--;
            if (m_ignore == 0) m_intr = 1'b0;
        end else if (s_seen != m_db) begin
            m_run++;
            if (m_run == DB) begin
                m_db  = s_seen;
                m_run = 0;
                if (m_db) begin
                    m_intr   = 1'b1;
                    m_count  = m_count + 8'd1;
                    m_ignore = PC;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".intr"},   int'(bif.INTR),        int'(m_intr));
        chk({tag, ".btn_db"}, int'(bif.BTN_DB),      int'(m_db));
        chk({tag, ".count"},  int'(bif.PRESS_COUNT), int'(m_count));
        if (bif.INTR && !prev_intr) obs_pulses++;
        prev_intr = bif.INTR;
    endtask

    task automatic cyc(input logic b);
        bif.BTN_IN = b;
        @(posedge CLK);
        model_edge(b);
        #1;
        check_all("cyc");
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        model_reset();
        #1;
        check_all("rst");
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    int   cnt_before;
    int   lvl;
    int   len;
    int   budget;
    logic pat [5];

    initial begin
        n_total = 0;
        n_pass  = 0;
        RESET      = 1'b1;
        bif.BTN_IN = 1'b0;
        model_reset();
        #1;
        check_all("reset_noclk");
        repeat (3) @(posedge CLK);
        #1;
        check_all("reset_clk");
        RESET = 1'b0;

        // clean press
        repeat (3) cyc(1'b0);
        repeat (20) cyc(1'b1);
        repeat (15) cyc(1'b0);
        chk("clean_count", int'(bif.PRESS_COUNT), 1);
        chk("clean_pulses", obs_pulses, 1);

        // bouncy press
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
        for (int i = 0; i < 5; i++) cyc(pat[i]);
        repeat (20) cyc(1'b1);
        repeat (15) cyc(1'b0);
        chk("bouncy_count", int'(bif.PRESS_COUNT), 2);
        chk("bouncy_pulses", obs_pulses, 2);

        // long hold with release bounce
        repeat (100) cyc(1'b1);
        cyc(1'b0); cyc(1'b1); cyc(1'b0);
        repeat (15) cyc(1'b0);
        chk("hold_pulses", obs_pulses, 3);
        chk("hold_btn_db", int'(bif.BTN_DB), 0);

        // glitch rejection
        cnt_before = int'(m_count);
        cyc(1'b1);
        repeat (10) cyc(1'b0);
        repeat (3) cyc(1'b1);
        repeat (10) cyc(1'b0);
        chk("glitch_count", int'(bif.PRESS_COUNT), cnt_before);
        chk("glitch_pulses", obs_pulses, 3);

        // random bursts
        repeat (200) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            repeat (len) cyc(lvl[0]);
        end
        repeat (20) cyc(1'b0);

        // counter wrap
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            repeat (12) cyc(1'b1);
            repeat (10) cyc(1'b0);
            if (i == 254) chk("wrap_255", int'(bif.PRESS_COUNT), 255);
        end
        chk("wrap_256", int'(bif.PRESS_COUNT), 0);
        chk("wrap_pulses", obs_pulses, 256);

        // reset in the middle of a pulse, button kept held
        repeat (3) cyc(1'b0);
        budget = 0;
        while (!m_intr && budget < 40) begin
            cyc(1'b1);
            budget++;
        end
        cyc(1'b1);
        chk("midpulse_intr_high", int'(bif.INTR), 1);
        #2;
        RESET = 1'b1;
        #1;
        chk("midpulse_intr_clr",  int'(bif.INTR), 0);
        chk("midpulse_db_clr",    int'(bif.BTN_DB), 0);
        chk("midpulse_count_clr", int'(bif.PRESS_COUNT), 0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        repeat (20) cyc(1'b1);
        chk("after_reset_pulses", obs_pulses, 1);
        chk("after_reset_count", int'(bif.PRESS_COUNT), 1);
        repeat (15) cyc(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/btn_intr_debounce.md
# btn_intr_debounce

Upstream conditioning stage for the RAT MCU wrapper. It takes a raw, bouncing push-button level and produces a clean, fixed-width interrupt pulse that drives the MCU `INTR` input. It also produces an 8-bit press counter that the wrapper's input-port mux can return on a dedicated port ID. Each debounced press yields exactly one interrupt pulse, regardless of contact bounce or hold duration.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000 — consecutive stable cycles required to accept a press or a release; minimum 2.
- `PULSE_CYCLES`, default 4 — width of the `INTR` pulse in clock cycles; minimum 1.

Ports:
- `CLK` input 1 — the single clock for the block; 50 MHz MCU clock domain; all state changes on rising edge.
- `RESET` input 1 — asynchronous, active-high reset; clears all state immediately.
- `BTN_IN` input 1 — raw asynchronous button level, active-high.
- `INTR` output 1 — registered one-shot interrupt pulse to MCU `INTR`.
- `BTN_DB` output 1 — registered debounced button level; high from press acceptance until release acceptance.
- `PRESS_COUNT` output 8 — registered count of accepted presses, wrapping.

## Operation
- `BTN_IN` passes through a 2-flop synchronizer. All FSM decisions use the synchronized level `s_btn`.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES).
- FSM states: `IDLE`, `PRESS_WAIT`, `PULSE`, `HELD`, `RELEASE_WAIT`.
- `IDLE`:
  - `s_btn` = 1 → go to `PRESS_WAIT`, counter = 1.
- `PRESS_WAIT`:
  - `s_btn` = 0 (bounce) → go to `IDLE`, counter = 0.
  - Counter reaches `DEBOUNCE_CYCLES` → go to `PULSE`. On the same edge: `INTR` and `BTN_DB` set to 1, `PRESS_COUNT` increments, pulse counter = 1.
  - Otherwise the counter increments.
- `PULSE`:
  - `INTR` holds at 1 for `PULSE_CYCLES` cycles total, then the FSM goes to `HELD` with `INTR` = 0.
  - The input level is ignored during `PULSE`; a release seen here is handled in `HELD`.
- `HELD`:
  - `s_btn` = 0 → go to `RELEASE_WAIT`, counter = 1.
- `RELEASE_WAIT`:
  - `s_btn` = 1 (bounce) → go to `HELD`.
  - Counter reaches `DEBOUNCE_CYCLES` → go to `IDLE` with `BTN_DB` = 0.
- `INTR` is never re-asserted until a full release is accepted and a new press is accepted.
- `PRESS_COUNT` wraps from 255 to 0 with no flag.

## Timing
- Reset values:
  - `INTR` = 0, `BTN_DB` = 0, `PRESS_COUNT` = 0x00.
  - FSM in `IDLE`; synchronizer flops = 0; counters = 0.
- Reset assertion clears every output asynchronously, with no clock needed. This includes mid-pulse: `INTR` drops at once and the FSM returns to `IDLE`.
- After reset deasserts, a button already held high is treated as a new press. It goes through the full debounce and produces one pulse.
- Press latency: let edge 0 be the first rising edge that samples `BTN_IN` = 1, with `BTN_IN` stable afterwards.
  - `s_btn` = 1 after edge 1.
  - `PRESS_WAIT` entered after edge 2.
  - `INTR` = 1 after edge `DEBOUNCE_CYCLES` + 1.
- `INTR` is high for exactly `PULSE_CYCLES` consecutive cycles.
- Release latency follows the same rule. `BTN_DB` falls after edge `DEBOUNCE_CYCLES` + 1, counted from the first edge sampling `BTN_IN` = 0. If the release happens during `PULSE`, counting starts when the FSM enters `HELD`.
- Any bounce shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.

## Structure
- Shared package `rat_io_pkg`:
  - state typedef `btn_state_t` (the five states above);
  - port-ID constants `BTN_COUNT_ID` = 8'h20 and `SWITCHES_ID` = 8'hFF;
  - output IDs `LEDS_ID` = 8'h40 and `SEG_ID` = 8'h81.
- One sub-module, `sync_2ff`: 1-bit, two-flop synchronizer with asynchronous active-high reset to 0.
- The FSM, debounce counter, pulse counter and press counter all live in `btn_intr_debounce`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `PULSE_CYCLES` = 3.
- Clean press: `BTN_IN` 0→1, held 20 cycles.
  - `INTR` = 1 after edges 5, 6, 7 and 0 after edge 8.
  - `BTN_DB` = 1 from edge 5.
  - `PRESS_COUNT` = 1.
- Bouncy press: `BTN_IN` toggles 1,0,1,1,0, then stable 1.
  - No `INTR` during the bounce.
  - Exactly one 3-cycle pulse, 5 edges after the start of the stable segment.
  - `PRESS_COUNT` = 1.
- Long hold with release bounce: held 100 cycles, then toggles 0,1,0, then stable 0.
  - Only one pulse in total.
  - `BTN_DB` falls 5 edges after the stable 0 begins.
- Counter wrap: 256 clean presses.
  - `PRESS_COUNT` reads 0xFF after 255 presses and 0x00 after 256.
  - 256 pulses observed.
- Reset mid-pulse: assert `RESET` while `INTR` = 1.
  - `INTR`, `BTN_DB` and `PRESS_COUNT` go to 0 before the next edge.
  - With the button still held, a new pulse appears 5 edges after reset deasserts.
- Glitch rejection: 1-cycle and 3-cycle high pulses on `BTN_IN`.
  - No `INTR`; `PRESS_COUNT` unchanged.
